// File: rtl/object_motion_ctrl.sv
// Motion controller for one rectangular game object: position, direction, step,
// bounce/exit edge handling, optional paddle-controlled y axis and run-state code.
module object_motion_ctrl #(
   parameter int H_SIZE     = 10,
   parameter int V_SIZE     = 10,
   parameter int IX         = 320,
   parameter int IY         = 240,
   parameter int IX_DIR     = 0,
   parameter int IY_DIR     = 1,
   parameter int D_WIDTH    = 639,
   parameter int D_HEIGHT   = 470,
   parameter int STEP_W     = 4,
   parameter int X_STOPPED  = 0,
   parameter int EDGE_MODE  = 0,
   parameter int Y_CTRL     = 0,
   parameter int AUTO_START = 0
) (
   input  logic              in_clock,
   input  logic              in_reset,
   input  logic              in_ani_stb,
   input  logic              in_animate,
   input  logic              in_serve,
   input  logic              in_hit,
   input  logic              in_up,
   input  logic              in_down,
   input  logic [STEP_W-1:0] in_x_step,
   input  logic [STEP_W-1:0] in_y_step,
   output logic [11:0]       out_x1,
   output logic [11:0]       out_x2,
   output logic [11:0]       out_y1,
   output logic [11:0]       out_y2,
   output logic              out_x_dir,
   output logic              out_y_dir,
   output logic              out_bounce_x,
   output logic              out_bounce_y,
   output logic              out_exit_left,
   output logic              out_exit_right,
   output logic [1:0]        out_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_OUT  = 2'b10
   } state_t;

   localparam logic [11:0] HS   = 12'(H_SIZE);
   localparam logic [11:0] VS   = 12'(V_SIZE);
   localparam logic [11:0] XMIN = 12'(H_SIZE);
   localparam logic [11:0] XMAX = 12'(D_WIDTH - H_SIZE);
   localparam logic [11:0] YMIN = 12'(V_SIZE);
   localparam logic [11:0] YMAX = 12'(D_HEIGHT - V_SIZE);
   localparam logic [11:0] X0   = 12'(IX);
   localparam logic [11:0] Y0   = 12'(IY);
   localparam logic        XD0  = (IX_DIR != 0);
   localparam logic        YD0  = (IY_DIR != 0);
   localparam state_t      ST0  = (AUTO_START != 0) ? S_RUN : S_IDLE;

   state_t      state_q, state_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic        x_dir_q, x_dir_d, y_dir_q, y_dir_d;
   logic        hit_q, hit_d;
   logic        bx_q, bx_d, by_q, by_d, el_q, el_d, er_q, er_d;

   logic        upd;
   logic        eff_xdir;
   logic [12:0] xs, ys, x_plus, y_plus, xmin_plus, ymin_plus;

   assign upd       = (state_q == S_RUN) && in_animate && in_ani_stb;
   assign xs        = 13'(in_x_step);
   assign ys        = 13'(in_y_step);
   assign x_plus    = {1'b0, x_q} + xs;
   assign y_plus    = {1'b0, y_q} + ys;
   assign xmin_plus = {1'b0, XMIN} + xs;
   assign ymin_plus = {1'b0, YMIN} + ys;
   // A pending hit flips the direction used for this update's step.
   assign eff_xdir  = x_dir_q ^ hit_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x_dir_d = x_dir_q;
      y_dir_d = y_dir_q;
      hit_d   = hit_q;
      bx_d    = 1'b0;
      by_d    = 1'b0;
      el_d    = 1'b0;
      er_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_serve) state_d = S_RUN;
         end
         S_OUT: begin
            if (in_serve) begin
               state_d = S_RUN;
               x_d     = X0;
               y_d     = Y0;
               x_dir_d = ~x_dir_q;
               hit_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (upd) begin
               if (X_STOPPED == 0) begin
                  x_dir_d = eff_xdir;
                  hit_d   = 1'b0;
                  if (xs != 13'd0) begin
                     if (!eff_xdir) begin
                        if (x_plus >= {1'b0, XMAX}) begin
                           x_d = XMAX;
                           if (EDGE_MODE == 0) begin
                              x_dir_d = 1'b1;
                              bx_d    = 1'b1;
                           end else begin
                              state_d = S_OUT;
                              er_d    = 1'b1;
                           end
                        end else begin
                           x_d = x_plus[11:0];
                        end
                     end else begin
                        if ({1'b0, x_q} <= xmin_plus) begin
                           x_d = XMIN;
                           if (EDGE_MODE == 0) begin
                              x_dir_d = 1'b0;
                              bx_d    = 1'b1;
                           end else begin
                              state_d = S_OUT;
                              el_d    = 1'b1;
                           end
                        end else begin
                           x_d = x_q - xs[11:0];
                        end
                     end
                  end
               end

               if (Y_CTRL == 0) begin
                  if (ys != 13'd0) begin
                     if (!y_dir_q) begin
                        if (y_plus >= {1'b0, YMAX}) begin
                           y_d     = YMAX;
                           y_dir_d = 1'b1;
                           by_d    = 1'b1;
                        end else begin
                           y_d = y_plus[11:0];
                        end
                     end else begin
                        if ({1'b0, y_q} <= ymin_plus) begin
                           y_d     = YMIN;
                           y_dir_d = 1'b0;
                           by_d    = 1'b1;
                        end else begin
                           y_d = y_q - ys[11:0];
                        end
                     end
                  end
               end else begin
                  // Paddle: clamp at the limits, never reverse or pulse.
                  if (in_up && !in_down) begin
                     y_dir_d = 1'b1;
                     y_d     = ({1'b0, y_q} <= ymin_plus) ? YMIN : (y_q - ys[11:0]);
                  end else if (in_down && !in_up) begin
                     y_dir_d = 1'b0;
                     y_d     = (y_plus >= {1'b0, YMAX}) ? YMAX : y_plus[11:0];
                  end
               end
            end
            if (in_hit && (X_STOPPED == 0)) hit_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q <= ST0;
         x_q     <= X0;
         y_q     <= Y0;
         x_dir_q <= XD0;
         y_dir_q <= YD0;
         hit_q   <= 1'b0;
         bx_q    <= 1'b0;
         by_q    <= 1'b0;
         el_q    <= 1'b0;
         er_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x_dir_q <= x_dir_d;
         y_dir_q <= y_dir_d;
         hit_q   <= hit_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         el_q    <= el_d;
         er_q    <= er_d;
      end
   end

   assign out_x1         = x_q - HS;
   assign out_x2         = x_q + HS;
   assign out_y1         = y_q - VS;
   assign out_y2         = y_q + VS;
   assign out_x_dir      = x_dir_q;
   assign out_y_dir      = y_dir_q;
   assign out_bounce_x   = bx_q;
   assign out_bounce_y   = by_q;
   assign out_exit_left  = el_q;
   assign out_exit_right = er_q;
   assign out_state      = state_q;

endmodule

// File: tb/tb_object_motion_ctrl.sv
// Directed bench: five differently-built instances share stimulus; each test
// resets all of them and checks the one instance it targets.
module tb_object_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst, stb, anim, serve, hit, up, down;
   logic [3:0] xstep, ystep;

   logic [11:0] x1[5], x2[5], y1[5], y2[5];
   logic        xd[5], yd[5], bx[5], by[5], el[5], er[5];
   logic [1:0]  st[5];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // 0: defaults, 1: bounce near right edge, 2: exit mode, 3: hit, 4: paddle
   object_motion_ctrl #(.IX(320)) u_a (
      .in_clock(clk), .in_reset(rst), .in_ani_stb(stb), .in_animate(anim), .in_serve(serve),
      .in_hit(hit), .in_up(up), .in_down(down), .in_x_step(xstep), .in_y_step(ystep),
      .out_x1(x1[0]), .out_x2(x2[0]), .out_y1(y1[0]), .out_y2(y2[0]), .out_x_dir(xd[0]),
      .out_y_dir(yd[0]), .out_bounce_x(bx[0]), .out_bounce_y(by[0]), .out_exit_left(el[0]),
      .out_exit_right(er[0]), .out_state(st[0]));

   object_motion_ctrl #(.IX(625), .AUTO_START(1)) u_b (
      .in_clock(clk), .in_reset(rst), .in_ani_stb(stb), .in_animate(anim), .in_serve(serve),
      .in_hit(hit), .in_up(up), .in_down(down), .in_x_step(xstep), .in_y_step(ystep),
      .out_x1(x1[1]), .out_x2(x2[1]), .out_y1(y1[1]), .out_y2(y2[1]), .out_x_dir(xd[1]),
      .out_y_dir(yd[1]), .out_bounce_x(bx[1]), .out_bounce_y(by[1]), .out_exit_left(el[1]),
      .out_exit_right(er[1]), .out_state(st[1]));

   object_motion_ctrl #(.IX(320), .IX_DIR(1), .EDGE_MODE(1), .AUTO_START(1)) u_c (
      .in_clock(clk), .in_reset(rst), .in_ani_stb(stb), .in_animate(anim), .in_serve(serve),
      .in_hit(hit), .in_up(up), .in_down(down), .in_x_step(xstep), .in_y_step(ystep),
      .out_x1(x1[2]), .out_x2(x2[2]), .out_y1(y1[2]), .out_y2(y2[2]), .out_x_dir(xd[2]),
      .out_y_dir(yd[2]), .out_bounce_x(bx[2]), .out_bounce_y(by[2]), .out_exit_left(el[2]),
      .out_exit_right(er[2]), .out_state(st[2]));

   object_motion_ctrl #(.IX(300), .AUTO_START(1)) u_d (
      .in_clock(clk), .in_reset(rst), .in_ani_stb(stb), .in_animate(anim), .in_serve(serve),
      .in_hit(hit), .in_up(up), .in_down(down), .in_x_step(xstep), .in_y_step(ystep),
      .out_x1(x1[3]), .out_x2(x2[3]), .out_y1(y1[3]), .out_y2(y2[3]), .out_x_dir(xd[3]),
      .out_y_dir(yd[3]), .out_bounce_x(bx[3]), .out_bounce_y(by[3]), .out_exit_left(el[3]),
      .out_exit_right(er[3]), .out_state(st[3]));

   object_motion_ctrl #(.IY(12), .Y_CTRL(1), .X_STOPPED(1), .AUTO_START(1)) u_e (
      .in_clock(clk), .in_reset(rst), .in_ani_stb(stb), .in_animate(anim), .in_serve(serve),
      .in_hit(hit), .in_up(up), .in_down(down), .in_x_step(xstep), .in_y_step(ystep),
      .out_x1(x1[4]), .out_x2(x2[4]), .out_y1(y1[4]), .out_y2(y2[4]), .out_x_dir(xd[4]),
      .out_y_dir(yd[4]), .out_bounce_x(bx[4]), .out_bounce_y(by[4]), .out_exit_left(el[4]),
      .out_exit_right(er[4]), .out_state(st[4]));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
   endtask

   task automatic strobe();
      stb = 1'b1; tick(); stb = 1'b0;
   endtask

   task automatic test_reset();
      xstep = 4'd1; ystep = 4'd1;
      do_reset();
      n_cmp++; if (x1[0] !== 12'd310) begin n_err++; $display("FAIL reset_x1 got %0d want 310", x1[0]); end
      n_cmp++; if (x2[0] !== 12'd330) begin n_err++; $display("FAIL reset_x2 got %0d want 330", x2[0]); end
      n_cmp++; if (y1[0] !== 12'd230) begin n_err++; $display("FAIL reset_y1 got %0d want 230", y1[0]); end
      n_cmp++; if (y2[0] !== 12'd250) begin n_err++; $display("FAIL reset_y2 got %0d want 250", y2[0]); end
      n_cmp++; if (st[0] !== 2'b00) begin n_err++; $display("FAIL reset_state got %0d want 0", st[0]); end
      n_cmp++; if ({xd[0], yd[0]} !== 2'b01) begin n_err++; $display("FAIL reset_dirs got %b want 01", {xd[0], yd[0]}); end
      n_cmp++; if ({bx[0], by[0], el[0], er[0]} !== 4'b0) begin n_err++; $display("FAIL reset_pulses got %b want 0000", {bx[0], by[0], el[0], er[0]}); end
      for (int i = 0; i < 5; i++) strobe();
      n_cmp++; if (x1[0] !== 12'd310 || y1[0] !== 12'd230) begin n_err++; $display("FAIL idle_hold got x1=%0d y1=%0d want 310/230", x1[0], y1[0]); end
      serve = 1'b1; tick(); serve = 1'b0;
      n_cmp++; if (st[0] !== 2'b01) begin n_err++; $display("FAIL serve_run got %0d want 1", st[0]); end
      n_cmp++; if (x1[0] !== 12'd310) begin n_err++; $display("FAIL serve_nomove got %0d want 310", x1[0]); end
      anim = 1'b0; xstep = 4'd2; strobe();
      n_cmp++; if (x1[0] !== 12'd310) begin n_err++; $display("FAIL freeze got %0d want 310", x1[0]); end
      anim = 1'b1; strobe();
      n_cmp++; if (x1[0] !== 12'd312) begin n_err++; $display("FAIL run_x1 got %0d want 312", x1[0]); end
      n_cmp++; if (y1[0] !== 12'd229) begin n_err++; $display("FAIL run_y1 got %0d want 229", y1[0]); end
   endtask

   task automatic test_bounce();
      xstep = 4'd3; ystep = 4'd0;
      do_reset();
      strobe();
      n_cmp++; if (x1[1] !== 12'd618) begin n_err++; $display("FAIL bounce_step1 got %0d want 618", x1[1]); end
      n_cmp++; if (bx[1] !== 1'b0 || xd[1] !== 1'b0) begin n_err++; $display("FAIL bounce_early got bx=%b dir=%b want 0/0", bx[1], xd[1]); end
      strobe();
      n_cmp++; if (x2[1] !== 12'd639) begin n_err++; $display("FAIL bounce_clamp got %0d want 639", x2[1]); end
      n_cmp++; if (xd[1] !== 1'b1 || bx[1] !== 1'b1) begin n_err++; $display("FAIL bounce_pulse got dir=%b bx=%b want 1/1", xd[1], bx[1]); end
      n_cmp++; if (y1[1] !== 12'd230 || by[1] !== 1'b0) begin n_err++; $display("FAIL bounce_y_static got y1=%0d by=%b want 230/0", y1[1], by[1]); end
      tick();
      n_cmp++; if (bx[1] !== 1'b0) begin n_err++; $display("FAIL bounce_one_cycle got %b want 0", bx[1]); end
      xstep = 4'd0; strobe();
      n_cmp++; if (x1[1] !== 12'd619 || bx[1] !== 1'b0) begin n_err++; $display("FAIL zero_step got x1=%0d bx=%b want 619/0", x1[1], bx[1]); end
   endtask

   task automatic test_exit();
      xstep = 4'd7; ystep = 4'd0;
      do_reset();
      for (int i = 0; i < 44; i++) strobe();
      n_cmp++; if (x1[2] !== 12'd2 || st[2] !== 2'b01) begin n_err++; $display("FAIL exit_approach got x1=%0d st=%0d want 2/1", x1[2], st[2]); end
      xstep = 4'd3; strobe();
      n_cmp++; if (x1[2] !== 12'd0) begin n_err++; $display("FAIL exit_clamp got %0d want 0", x1[2]); end
      n_cmp++; if (st[2] !== 2'b10) begin n_err++; $display("FAIL exit_state got %0d want 2", st[2]); end
      n_cmp++; if (el[2] !== 1'b1 || er[2] !== 1'b0) begin n_err++; $display("FAIL exit_pulse got el=%b er=%b want 1/0", el[2], er[2]); end
      tick();
      n_cmp++; if (el[2] !== 1'b0) begin n_err++; $display("FAIL exit_one_cycle got %b want 0", el[2]); end
      strobe();
      n_cmp++; if (x1[2] !== 12'd0) begin n_err++; $display("FAIL out_frozen got %0d want 0", x1[2]); end
      serve = 1'b1; tick(); serve = 1'b0;
      n_cmp++; if (x1[2] !== 12'd310 || xd[2] !== 1'b0 || st[2] !== 2'b01) begin n_err++; $display("FAIL serve_reload got x1=%0d dir=%b st=%0d want 310/0/1", x1[2], xd[2], st[2]); end
   endtask

   task automatic test_hit();
      xstep = 4'd2; ystep = 4'd0;
      do_reset();
      tick(); hit = 1'b1; tick(); hit = 1'b0; tick();
      strobe();
      n_cmp++; if (x1[3] !== 12'd288 || xd[3] !== 1'b1) begin n_err++; $display("FAIL hit_reverse got x1=%0d dir=%b want 288/1", x1[3], xd[3]); end
      strobe();
      n_cmp++; if (x1[3] !== 12'd286 || xd[3] !== 1'b1) begin n_err++; $display("FAIL hit_once got x1=%0d dir=%b want 286/1", x1[3], xd[3]); end
   endtask

   task automatic test_paddle();
      xstep = 4'd4; ystep = 4'd4;
      do_reset();
      up = 1'b1; hit = 1'b1; strobe(); hit = 1'b0;
      n_cmp++; if (y1[4] !== 12'd0 || yd[4] !== 1'b1) begin n_err++; $display("FAIL paddle_clamp got y1=%0d dir=%b want 0/1", y1[4], yd[4]); end
      strobe();
      n_cmp++; if (y1[4] !== 12'd0 || by[4] !== 1'b0) begin n_err++; $display("FAIL paddle_hold got y1=%0d by=%b want 0/0", y1[4], by[4]); end
      down = 1'b1; strobe();
      n_cmp++; if (y1[4] !== 12'd0) begin n_err++; $display("FAIL paddle_both got %0d want 0", y1[4]); end
      up = 1'b0; strobe(); down = 1'b0;
      n_cmp++; if (y1[4] !== 12'd4 || yd[4] !== 1'b0) begin n_err++; $display("FAIL paddle_down got y1=%0d dir=%b want 4/0", y1[4], yd[4]); end
      n_cmp++; if (x1[4] !== 12'd310 || xd[4] !== 1'b0) begin n_err++; $display("FAIL x_stopped got x1=%0d dir=%b want 310/0", x1[4], xd[4]); end
   endtask

   task automatic test_reset_on_strobe();
      xstep = 4'd3; ystep = 4'd0;
      do_reset();
      strobe();
      rst = 1'b1; stb = 1'b1; tick(); rst = 1'b0; stb = 1'b0;
      n_cmp++; if (x1[1] !== 12'd615 || xd[1] !== 1'b0) begin n_err++; $display("FAIL rst_strobe_pos got x1=%0d dir=%b want 615/0", x1[1], xd[1]); end
      n_cmp++; if (bx[1] !== 1'b0) begin n_err++; $display("FAIL rst_strobe_pulse got %b want 0", bx[1]); end
      tick();
      n_cmp++; if (bx[1] !== 1'b0 || st[1] !== 2'b01) begin n_err++; $display("FAIL rst_strobe_after got bx=%b st=%0d want 0/1", bx[1], st[1]); end
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; anim = 1'b1; serve = 1'b0; hit = 1'b0;
      up = 1'b0; down = 1'b0; xstep = 4'd0; ystep = 4'd0;
      tick();
      test_reset();
      test_bounce();
      test_exit();
      test_hit();
      test_paddle();
      test_reset_on_strobe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/object_motion_ctrl.md
Name: object_motion_ctrl

Overview:
Parametrised successor to the bouncing-object animator for the VGA game layer. It tracks one rectangular object: position, per-axis direction and runtime-programmable step size. Edge handling is selectable per build: bounce with exact clamping, or exit-and-score on left/right. An optional player-controlled vertical axis makes it a paddle. It emits edge/exit event pulses and a run-state code to the game FSM, and drives the same x1/x2/y1/y2 edge outputs to the pixel renderer.

Parameters:
H_SIZE, 10, half object width
V_SIZE, 10, half object height
IX, 320, reset horizontal centre
IY, 240, reset vertical centre
IX_DIR, 0, reset horizontal direction (0 right, 1 left)
IY_DIR, 1, reset vertical direction (0 down, 1 up)
D_WIDTH, 639, display width limit
D_HEIGHT, 470, display height limit
STEP_W, 4, width of runtime step inputs
X_STOPPED, 0, 1 = x axis never moves
EDGE_MODE, 0, 0 = bounce on left/right; 1 = exit on left/right
Y_CTRL, 0, 0 = y autonomous bounce; 1 = y driven by in_up/in_down
AUTO_START, 0, 1 = leave reset directly in RUN

Ports:
in_clock  in  1  base clock
in_reset  in  1  synchronous active-high reset
in_ani_stb  in  1  one-cycle animation strobe (1 per frame)
in_animate  in  1  motion enable; low = freeze, state kept
in_serve  in  1  IDLE/OUT -> RUN request
in_hit  in  1  external collision; reverses x direction at next strobe
in_up  in  1  paddle up (Y_CTRL=1)
in_down  in  1  paddle down (Y_CTRL=1)
in_x_step  in  STEP_W  pixels per strobe, x
in_y_step  in  STEP_W  pixels per strobe, y
out_x1, out_x2, out_y1, out_y2  out  12 each  object edges: centre -/+ H_SIZE or V_SIZE
out_x_dir, out_y_dir  out  1 each  current directions
out_bounce_x, out_bounce_y  out  1 each  one-cycle pulse on edge reversal
out_exit_left, out_exit_right  out  1 each  one-cycle pulse on exit (EDGE_MODE=1)
out_state  out  2  00 IDLE, 01 RUN, 10 OUT

Behaviour:
- Reset (in_reset=1 at posedge):
  - x=IX, y=IY, x_dir=IX_DIR, y_dir=IY_DIR.
  - State = RUN if AUTO_START else IDLE.
  - All pulses 0; pending hit cleared.
  - Reset wins over every other input, including mid-strobe.
- Limits (12-bit unsigned): XMIN=H_SIZE, XMAX=D_WIDTH-H_SIZE, YMIN=V_SIZE, YMAX=D_HEIGHT-V_SIZE.
- Edge outputs are combinational from registered x and y.
- Event pulses are registered: high exactly one cycle, the cycle after the qualifying strobe edge.
- An "update" is the cycle where state=RUN, in_animate=1 and in_ani_stb=1. Position and direction change only on updates, except reset, and serve in OUT.
- IDLE:
  - Position held.
  - in_serve=1 -> RUN next cycle; no movement that cycle.
- OUT:
  - Position frozen at the exit edge.
  - in_serve=1 -> reload x=IX, y=IY, x_dir = inverse of exit side (exit left -> right); state RUN.
- in_hit:
  - Any cycle in RUN sets a pending flag.
  - At the next update, x_dir is inverted before the x step is computed; the flag then clears.
  - No effect when X_STOPPED=1.
- X axis per update (X_STOPPED=0), s=in_x_step zero-extended:
  - Moving right: if x+s >= XMAX, then
    - EDGE_MODE=0: x=XMAX, x_dir=1, bounce_x pulse.
    - EDGE_MODE=1: x=XMAX, state=OUT, exit_right pulse.
  - Moving right otherwise: x=x+s.
  - Moving left mirrors this: if x <= XMIN+s, then x=XMIN and reverse or exit_left.
  - Equality counts as reaching the edge.
  - s=0: no move, no pulse, even when sitting at an edge.
- Y axis, Y_CTRL=0: same clamp/reverse rule with YMIN/YMAX and in_y_step; always bounces, never exits; bounce_y pulse.
- Y axis, Y_CTRL=1:
  - in_up only: y = max(YMIN, y-s).
  - in_down only: y = min(YMAX, y+s).
  - Both or neither: hold.
  - No bounce_y; out_y_dir shows last commanded direction.
- X exit and Y bounce on the same update:
  - Both pulses assert.
  - y still updates that cycle.
- in_animate=0 or in_ani_stb=0: all registers hold; pending hit retained.
- Step inputs are sampled only on update cycles.

Test Plan:
- Reset with AUTO_START=0, IX=320, IY=240 -> out_x1=310, out_x2=330, out_y1=230, out_y2=250, state=00; 5 strobes -> no motion; in_serve -> state=01.
- RUN, x=625, right, step 3, XMAX=629, EDGE_MODE=0 -> x=628 on 1st strobe, then x=629, x_dir=1, bounce_x single-cycle pulse on 2nd.
- EDGE_MODE=1, x=12, left, step 3, XMIN=10 -> x=10, state=10, exit_left pulse; in_serve -> x=320, x_dir=0, state=01.
- in_hit mid-frame with x=300, right, step 2 -> x=298 at next strobe, x_dir=1; hit not reapplied on following strobe (x=296).
- Y_CTRL=1, y=12, in_up, step 4, YMIN=10 -> y=10 and holds; in_up+in_down -> no change.
- Reset asserted on the same cycle as a strobe at an edge -> registers return to IX/IY, no pulses.
